// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
// ---------------------------------------------------------------------------
// Arbitrates two write sources (ALU writeback and memory/load path) onto the
// register file's single write port. Each source owns a one-entry buffer
// behind a valid/ready handshake; at most one buffered entry is granted per
// cycle and presented on a registered REG_WR / REG_DEST / WRITE_DATA port.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   ALU_VALID/READY       ALU request handshake, ALU_DEST / ALU_DATA payload
//   MEM_VALID/READY       memory request handshake, MEM_DEST / MEM_DATA payload
//   REG_WR, REG_DEST,     registered register-file write port
//   WRITE_DATA
//   PENDING               bit d set while a buffered entry targets register d
//   CONFLICT_CNT          saturating count of both-buffers-full cycles
//
// Configuration
//   REG_WR_ARB_STATS_EN   when defined, CONFLICT_CNT is a live counter;
//                         otherwise it is tied to zero and has no flops.
// ---------------------------------------------------------------------------
module reg_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ALU_VALID,
    output logic                   ALU_READY,
    input  logic [ADDR_W-1:0]      ALU_DEST,
    input  logic [DATA_W-1:0]      ALU_DATA,
    input  logic                   MEM_VALID,
    output logic                   MEM_READY,
    input  logic [ADDR_W-1:0]      MEM_DEST,
    input  logic [DATA_W-1:0]      MEM_DATA,
    output logic                   REG_WR,
    output logic [ADDR_W-1:0]      REG_DEST,
    output logic [DATA_W-1:0]      WRITE_DATA,
    output logic [2**ADDR_W-1:0]   PENDING,
    output logic [7:0]             CONFLICT_CNT
);

    localparam int NREG = 2**ADDR_W;

    // Buffer state. The *_young_reg bit marks an entry that was loaded while
    // the other buffer was already holding an entry, i.e. the younger one.
    logic              alu_full_reg, mem_full_reg;
    logic [ADDR_W-1:0] alu_dest_reg, mem_dest_reg;
    logic [DATA_W-1:0] alu_data_reg, mem_data_reg;
    logic              alu_young_reg, mem_young_reg;
    logic              rr_alu_reg;      // 1: ALU has round-robin priority

    logic              reg_wr_reg;
    logic [ADDR_W-1:0] reg_dest_reg;
    logic [DATA_W-1:0] write_data_reg;

    logic              grant_alu, grant_mem;
    logic              alu_accept, mem_accept;
    logic [ADDR_W-1:0] sel_dest;
    logic [DATA_W-1:0] sel_data;
    logic              sel_unimpl;
    logic              both_full;

    assign both_full = alu_full_reg && mem_full_reg;

    // Grant selection over the full buffers.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (both_full) begin
            if (alu_dest_reg == mem_dest_reg) begin
                // Same target: oldest first. On a tie MEM goes first so the
                // ALU value is the one left in the register.
                if (mem_young_reg) grant_alu = 1'b1;
                else               grant_mem = 1'b1;
            end else if (rr_alu_reg) begin
                grant_alu = 1'b1;
            end else begin
                grant_mem = 1'b1;
            end
        end else if (alu_full_reg) begin
            grant_alu = 1'b1;
        end else if (mem_full_reg) begin
            grant_mem = 1'b1;
        end
    end

    // READY never looks at the requester's own VALID; a buffer being drained
    // this cycle can accept a new entry at the same edge.
    assign ALU_READY  = !RESET && (!alu_full_reg || grant_alu);
    assign MEM_READY  = !RESET && (!mem_full_reg || grant_mem);
    assign alu_accept = ALU_VALID && ALU_READY;
    assign mem_accept = MEM_VALID && MEM_READY;

    always_comb begin
        sel_dest = mem_dest_reg;
        sel_data = mem_data_reg;
        if (grant_alu) begin
            sel_dest = alu_dest_reg;
            sel_data = alu_data_reg;
        end
    end

    // Registers 3 and 7 do not exist: such writes are drained but squashed.
    assign sel_unimpl = (sel_dest[1:0] == 2'b11);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_full_reg   <= 1'b0;
            mem_full_reg   <= 1'b0;
            alu_dest_reg   <= '0;
            mem_dest_reg   <= '0;
            alu_data_reg   <= '0;
            mem_data_reg   <= '0;
            alu_young_reg  <= 1'b0;
            mem_young_reg  <= 1'b0;
            rr_alu_reg     <= 1'b1;
            reg_wr_reg     <= 1'b0;
            reg_dest_reg   <= '0;
            write_data_reg <= '0;
        end else begin
            alu_full_reg <= alu_accept || (alu_full_reg && !grant_alu);
            mem_full_reg <= mem_accept || (mem_full_reg && !grant_mem);

            if (alu_accept) begin
                alu_dest_reg  <= ALU_DEST;
                alu_data_reg  <= ALU_DATA;
                // Younger only if the MEM entry survives this edge.
                alu_young_reg <= mem_full_reg && !grant_mem;
            end else if (mem_accept) begin
                alu_young_reg <= 1'b0;
            end

            if (mem_accept) begin
                mem_dest_reg  <= MEM_DEST;
                mem_data_reg  <= MEM_DATA;
                mem_young_reg <= alu_full_reg && !grant_alu;
            end else if (alu_accept) begin
                mem_young_reg <= 1'b0;
            end

            if (grant_alu || grant_mem) begin
                // Priority passes to the requester not granted now.
                rr_alu_reg <= grant_mem;
                if (sel_unimpl) begin
                    reg_wr_reg <= 1'b0;
                end else begin
                    reg_wr_reg     <= 1'b1;
                    reg_dest_reg   <= sel_dest;
                    write_data_reg <= sel_data;
                end
            end else begin
                reg_wr_reg <= 1'b0;
            end
        end
    end

    assign REG_WR     = reg_wr_reg;
    assign REG_DEST   = reg_dest_reg;
    assign WRITE_DATA = write_data_reg;

    // Hazard mask from buffered entries only; the output stage is excluded.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pending
            assign PENDING[gi] = (alu_full_reg && (alu_dest_reg == ADDR_W'(gi))) ||
                                 (mem_full_reg && (mem_dest_reg == ADDR_W'(gi)));
        end
    endgenerate

`ifdef REG_WR_ARB_STATS_EN
    logic [7:0] conflict_cnt_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            conflict_cnt_reg <= 8'h00;
        end else if (both_full && (conflict_cnt_reg != 8'hFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 8'h01;
        end
    end

    assign CONFLICT_CNT = conflict_cnt_reg;
`else
    assign CONFLICT_CNT = 8'h00;
`endif

endmodule
